// File: rtl/ship_controller.sv
// Player-ship controller: synchronised buttons, tick-paced saturating movement
// with hold-to-repeat, and a single-projectile shot engine.
module ship_controller #(
  parameter int POS_W        = 11,
  parameter int X_MIN        = 134,
  parameter int X_MAX        = 765,
  parameter int X_START      = 445,
  parameter int STEP         = 16,
  parameter int TICK_DIV     = 524288,
  parameter int REPEAT_TICKS = 4,
  parameter int SHOT_Y_START = 470,
  parameter int SHOT_Y_MIN   = 55,
  parameter int SHOT_STEP    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_fire,
  input  logic             btn_restart,
  input  logic             hit,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] shot_x,
  output logic [POS_W-1:0] shot_y,
  output logic             shot_active,
  output logic             fire_pulse,
  output logic             moving
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
  localparam logic [REP_W-1:0]  REP_LAST     = REP_W'(REPEAT_TICKS - 1);
  localparam logic [POS_W-1:0]  X_MIN_P      = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]  X_MAX_P      = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]  X_START_P    = POS_W'(X_START);
  localparam logic [POS_W-1:0]  STEP_P       = POS_W'(STEP);
  localparam logic [POS_W:0]    STEP_E       = (POS_W + 1)'(STEP);
  localparam logic [POS_W:0]    X_MAX_E      = (POS_W + 1)'(X_MAX);
  localparam logic [POS_W:0]    X_MIN_STEP_E = (POS_W + 1)'(X_MIN + STEP);
  localparam logic [POS_W-1:0]  SHOT_START_P = POS_W'(SHOT_Y_START);
  localparam logic [POS_W-1:0]  SHOT_STEP_P  = POS_W'(SHOT_STEP);
  localparam logic [POS_W-1:0]  SHOT_LIMIT_P = POS_W'(SHOT_Y_MIN + SHOT_STEP);

  localparam logic [0:0] MV_IDLE = 1'b0;
  localparam logic [0:0] MV_HOLD = 1'b1;
  localparam logic [0:0] SH_IDLE = 1'b0;
  localparam logic [0:0] SH_FLY  = 1'b1;

  logic [1:0]        left_sync_r, right_sync_r, fire_sync_r, restart_sync_r;
  logic              fire_prev_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              fire_req_r;
  logic [0:0]        mv_state_r;
  logic [0:0]        shot_state_r;
  logic              dir_right_r;
  logic [REP_W-1:0]  rep_cnt_r;

  logic left_pressed_s, right_pressed_s, fire_pressed_s, restart_s;
  logic tick_s, fire_edge_s, dir_held_s;

  function automatic logic [POS_W-1:0] step_right(input logic [POS_W-1:0] pos);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + STEP_E;
    if (sum > X_MAX_E) step_right = X_MAX_P;
    else               step_right = sum[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] step_left(input logic [POS_W-1:0] pos);
    if ({1'b0, pos} < X_MIN_STEP_E) step_left = X_MIN_P;
    else                            step_left = pos - STEP_P;
  endfunction

  assign left_pressed_s  = ~left_sync_r[1];
  assign right_pressed_s = ~right_sync_r[1];
  assign fire_pressed_s  = ~fire_sync_r[1];
  assign restart_s       = ~restart_sync_r[1];
  assign tick_s          = (tick_cnt_r == TICK_LAST);
  assign fire_edge_s     = fire_prev_r & fire_pressed_s;
  assign dir_held_s      = dir_right_r ? (right_pressed_s & ~left_pressed_s)
                                       : (left_pressed_s & ~right_pressed_s);

  // Button synchronisers (released = 1) and the previous synced fire level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_sync_r    <= 2'b11;
      right_sync_r   <= 2'b11;
      fire_sync_r    <= 2'b11;
      restart_sync_r <= 2'b11;
      fire_prev_r    <= 1'b1;
    end else begin
      left_sync_r    <= {left_sync_r[0], btn_left};
      right_sync_r   <= {right_sync_r[0], btn_right};
      fire_sync_r    <= {fire_sync_r[0], btn_fire};
      restart_sync_r <= {restart_sync_r[0], btn_restart};
      fire_prev_r    <= fire_sync_r[1];
    end
  end

  // Game tick divider and the pending fire request; a request lives one tick at most.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      fire_req_r <= 1'b0;
    end else if (restart_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      fire_req_r <= 1'b0;
    end else begin
      tick_cnt_r <= tick_s ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
      if (fire_edge_s)  fire_req_r <= 1'b1;
      else if (tick_s)  fire_req_r <= 1'b0;
      else              fire_req_r <= fire_req_r;
    end
  end

  // Shot engine: launch from the pre-move ship position; hit wins over the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shot_state_r <= SH_IDLE;
      shot_x       <= {POS_W{1'b0}};
      shot_y       <= {POS_W{1'b0}};
      shot_active  <= 1'b0;
      fire_pulse   <= 1'b0;
    end else if (restart_s) begin
      shot_state_r <= SH_IDLE;
      shot_x       <= {POS_W{1'b0}};
      shot_y       <= {POS_W{1'b0}};
      shot_active  <= 1'b0;
      fire_pulse   <= 1'b0;
    end else begin
      fire_pulse <= 1'b0;
      if (shot_state_r == SH_FLY && hit) begin
        shot_state_r <= SH_IDLE;
        shot_active  <= 1'b0;
      end else if (tick_s) begin
        case (shot_state_r)
          SH_FLY: begin
            if (shot_y < SHOT_LIMIT_P) begin
              shot_state_r <= SH_IDLE;
              shot_active  <= 1'b0;
            end else begin
              shot_y <= shot_y - SHOT_STEP_P;
            end
          end
          SH_IDLE: begin
            if (fire_req_r) begin
              shot_x       <= pos_x;
              shot_y       <= SHOT_START_P;
              shot_active  <= 1'b1;
              fire_pulse   <= 1'b1;
              shot_state_r <= SH_FLY;
            end
          end
          default: begin
            shot_state_r <= SH_IDLE;
            shot_active  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Movement FSM: first step on press, then one step every REPEAT_TICKS while held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv_state_r  <= MV_IDLE;
      dir_right_r <= 1'b0;
      rep_cnt_r   <= {REP_W{1'b0}};
      pos_x       <= X_START_P;
      moving      <= 1'b0;
    end else if (restart_s) begin
      mv_state_r  <= MV_IDLE;
      dir_right_r <= 1'b0;
      rep_cnt_r   <= {REP_W{1'b0}};
      pos_x       <= X_START_P;
      moving      <= 1'b0;
    end else if (tick_s) begin
      case (mv_state_r)
        MV_IDLE: begin
          if (left_pressed_s != right_pressed_s) begin
            dir_right_r <= right_pressed_s;
            pos_x       <= right_pressed_s ? step_right(pos_x) : step_left(pos_x);
            rep_cnt_r   <= {REP_W{1'b0}};
            mv_state_r  <= MV_HOLD;
            moving      <= 1'b1;
          end
        end
        MV_HOLD: begin
          if (!dir_held_s) begin
            mv_state_r <= MV_IDLE;
            moving     <= 1'b0;
          end else if (rep_cnt_r == REP_LAST) begin
            pos_x     <= dir_right_r ? step_right(pos_x) : step_left(pos_x);
            rep_cnt_r <= {REP_W{1'b0}};
          end else begin
            rep_cnt_r <= rep_cnt_r + REP_W'(1);
          end
        end
        default: begin
          mv_state_r <= MV_IDLE;
          moving     <= 1'b0;
        end
      endcase
    end
  end

  ship_controller_chk #(
    .POS_W(POS_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_START(X_START), .STEP(STEP),
    .TICK_DIV(TICK_DIV), .REPEAT_TICKS(REPEAT_TICKS),
    .SHOT_Y_START(SHOT_Y_START), .SHOT_Y_MIN(SHOT_Y_MIN)
  ) u_chk (.clk(clk));

endmodule

// Parameter legality checker.
module ship_controller_chk #(
  parameter int POS_W        = 11,
  parameter int X_MIN        = 134,
  parameter int X_MAX        = 765,
  parameter int X_START      = 445,
  parameter int STEP         = 16,
  parameter int TICK_DIV     = 524288,
  parameter int REPEAT_TICKS = 4,
  parameter int SHOT_Y_START = 470,
  parameter int SHOT_Y_MIN   = 55
) (
  input logic clk
);
  localparam bit PARAMS_OK = (X_MIN + STEP <= X_MAX) && (X_MIN <= X_START) &&
                             (X_START <= X_MAX) && (SHOT_Y_MIN < SHOT_Y_START) &&
                             (X_MAX < 2 ** POS_W) && (SHOT_Y_START < 2 ** POS_W) &&
                             (TICK_DIV >= 2) && (REPEAT_TICKS >= 1);

  a_params_legal: assert property (@(posedge clk) PARAMS_OK);
endmodule

// File: tb/tb_ship_controller.sv
// Scoreboarded bench for ship_controller: a behavioural reference pushes the
// expected outputs at each clock edge, the sampled DUT outputs are popped against it.
module tb_ship_controller;
  localparam int TD = 4;
  localparam int RT = 2;

  logic        clk, reset;
  logic        b_left, b_right, b_fire, b_restart, hit;
  logic [10:0] pos_x, shot_x, shot_y;
  logic        shot_active, fire_pulse, moving;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  // reference state
  int m_pos, m_sx, m_sy, m_cnt, m_rep;
  bit m_fly, m_fp, m_hold, m_dir, m_freq, m_fprev;
  bit dl_l[2], dl_r[2], dl_f[2], dl_rs[2];

  ship_controller #(.TICK_DIV(TD), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .reset(reset), .btn_left(b_left), .btn_right(b_right),
    .btn_fire(b_fire), .btn_restart(b_restart), .hit(hit),
    .pos_x(pos_x), .shot_x(shot_x), .shot_y(shot_y),
    .shot_active(shot_active), .fire_pulse(fire_pulse), .moving(moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int ref_step(int p, bit right);
    if (right) return (p + 16 > 765) ? 765 : p + 16;
    return (p - 16 < 134) ? 134 : p - 16;
  endfunction

  task automatic m_game_reset();
    m_pos = 445; m_sx = 0; m_sy = 0; m_fly = 0; m_fp = 0;
    m_hold = 0; m_dir = 0; m_rep = 0; m_freq = 0; m_cnt = 0;
  endtask

  task automatic m_reset();
    m_game_reset();
    m_fprev = 1;
    for (int i = 0; i < 2; i++) begin
      dl_l[i] = 1; dl_r[i] = 1; dl_f[i] = 1; dl_rs[i] = 1;
    end
  endtask

  // one clock edge of the reference, seeing buttons two edges late
  task automatic m_step();
    bit sl, sr, sf, srs, tick, fedge, pl, pr;
    sl = dl_l[1]; sr = dl_r[1]; sf = dl_f[1]; srs = dl_rs[1];
    dl_l[1] = dl_l[0]; dl_r[1] = dl_r[0]; dl_f[1] = dl_f[0]; dl_rs[1] = dl_rs[0];
    dl_l[0] = b_left; dl_r[0] = b_right; dl_f[0] = b_fire; dl_rs[0] = b_restart;
    fedge = m_fprev && !sf;
    m_fprev = sf;
    if (!srs) begin
      m_game_reset();
      return;
    end
    tick = (m_cnt == TD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_fp = 0;
    if (m_fly && hit) m_fly = 0;
    else if (tick && m_fly) begin
      if (m_sy - 8 < 55) m_fly = 0;
      else m_sy = m_sy - 8;
    end else if (tick && m_freq) begin
      m_sx = m_pos; m_sy = 470; m_fly = 1; m_fp = 1;
    end
    if (fedge) m_freq = 1;
    else if (tick) m_freq = 0;
    if (tick) begin
      pl = !sl; pr = !sr;
      if (!m_hold) begin
        if (pl != pr) begin
          m_dir = pr; m_pos = ref_step(m_pos, pr); m_rep = 0; m_hold = 1;
        end
      end else if ((m_dir && pr && !pl) || (!m_dir && pl && !pr)) begin
        if (m_rep == RT - 1) begin m_pos = ref_step(m_pos, m_dir); m_rep = 0; end
        else m_rep++;
      end else m_hold = 0;
    end
  endtask

  task automatic cycle();
    logic [63:0] e, got;
    @(posedge clk);
    if (!reset) m_reset();
    else m_step();
    exp_q.push_back({28'd0, 11'(m_pos), 11'(m_sx), 11'(m_sy), m_fly, m_fp, m_hold});
    @(negedge clk);
    e = exp_q.pop_front();
    got = {28'd0, pos_x, shot_x, shot_y, shot_active, fire_pulse, moving};
    check("outputs", got, e);
  endtask

  task automatic restart_pulse();
    b_restart = 1'b0;
    repeat (3) cycle();
    b_restart = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic press_fire();
    b_fire = 1'b0;
    repeat (2) cycle();
    b_fire = 1'b1;
  endtask

  task automatic wait_pulse(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (fire_pulse) seen = 1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int maxp, minp, extra, last_y;
    bit saw;
    reset = 1'b0; b_left = 1'b1; b_right = 1'b1; b_fire = 1'b1; b_restart = 1'b1; hit = 1'b0;
    m_reset();
    repeat (3) cycle();
    check("reset_pos", 64'(pos_x), 64'd445);
    reset = 1'b1;

    // async reset mid-run
    b_right = 1'b0;
    repeat (12) cycle();
    b_right = 1'b1;
    press_fire();
    wait_pulse("pre_reset_fire");
    reset = 1'b0;
    m_reset();
    #1;
    check("async_pos", 64'(pos_x), 64'd445);
    check("async_shot", 64'(shot_active), 64'd0);
    check("async_pulse", 64'(fire_pulse), 64'd0);
    check("async_moving", 64'(moving), 64'd0);
    repeat (2) cycle();
    reset = 1'b1;
    repeat (20 * TD) cycle();
    check("idle_pos", 64'(pos_x), 64'd445);

    // right hold with saturation
    b_right = 1'b0;
    for (int i = 0; i < 20 && pos_x == 11'd445; i++) cycle();
    check("first_right", 64'(pos_x), 64'd461);
    saw = 0; maxp = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (pos_x == 11'd749) saw = 1;
      if (int'(pos_x) > maxp) maxp = pos_x;
    end
    check("saw_749", 64'(saw), 64'd1);
    check("max_right", 64'(maxp), 64'd765);
    check("sat_right", 64'(pos_x), 64'd765);
    check("moving_held", 64'(moving), 64'd1);
    b_right = 1'b1;
    repeat (3 * TD) cycle();
    check("moving_release", 64'(moving), 64'd0);

    // left hold with saturation
    restart_pulse();
    check("restart_pos", 64'(pos_x), 64'd445);
    b_left = 1'b0;
    saw = 0; minp = 1000;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (pos_x == 11'd141) saw = 1;
      if (int'(pos_x) < minp) minp = pos_x;
    end
    b_left = 1'b1;
    check("saw_141", 64'(saw), 64'd1);
    check("min_left", 64'(minp), 64'd134);
    check("sat_left", 64'(pos_x), 64'd134);

    // both held, then right straight into left
    restart_pulse();
    b_left = 1'b0; b_right = 1'b0;
    repeat (10 * TD) cycle();
    check("both_pos", 64'(pos_x), 64'd445);
    check("both_moving", 64'(moving), 64'd0);
    b_left = 1'b1;
    repeat (3 * TD) cycle();
    check("right_phase", 64'(pos_x > 11'd445), 64'd1);
    b_right = 1'b1; b_left = 1'b0;
    repeat (6 * TD) cycle();
    b_left = 1'b1;
    check("left_phase", 64'(pos_x < 11'd445), 64'd1);

    // fire, full flight, dropped second press
    restart_pulse();
    press_fire();
    wait_pulse("fire_launch");
    check("launch_x", 64'(shot_x), 64'd445);
    check("launch_y", 64'(shot_y), 64'd470);
    check("launch_active", 64'(shot_active), 64'd1);
    cycle();
    check("pulse_width", 64'(fire_pulse), 64'd0);
    repeat (5 * TD) cycle();
    press_fire();
    extra = 0; last_y = 0;
    for (int i = 0; i < 600 && shot_active; i++) begin
      last_y = shot_y;
      cycle();
      if (fire_pulse) extra++;
    end
    check("no_refire", 64'(extra), 64'd0);
    check("flight_end", 64'(shot_active), 64'd0);
    check("last_y", 64'(last_y), 64'd62);
    check("y_hold", 64'(shot_y), 64'd62);

    // hit off-tick and on a tick cycle
    press_fire();
    wait_pulse("fire_hit1");
    repeat (3 * TD + 1) cycle();
    hit = 1'b1;
    cycle();
    hit = 1'b0;
    check("hit_clear", 64'(shot_active), 64'd0);
    repeat (TD) cycle();
    press_fire();
    wait_pulse("fire_hit2");
    cycle();
    for (int i = 0; i < 2 * TD && m_cnt != TD - 1; i++) cycle();
    hit = 1'b1;
    cycle();
    hit = 1'b0;
    check("hit_on_tick", 64'(shot_active), 64'd0);

    // restart mid-flight after moving
    b_right = 1'b0;
    repeat (2 * TD) cycle();
    b_right = 1'b1;
    press_fire();
    wait_pulse("fire_restart");
    repeat (2 * TD) cycle();
    b_restart = 1'b0;
    repeat (3) cycle();
    check("rst_pos", 64'(pos_x), 64'd445);
    check("rst_shot", 64'(shot_active), 64'd0);
    check("rst_y", 64'(shot_y), 64'd0);
    b_restart = 1'b1;
    repeat (2 * TD) cycle();
    b_left = 1'b0;
    repeat (4 * TD) cycle();
    b_left = 1'b1;
    repeat (2 * TD) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ship_controller.md
Name: ship_controller

Overview:
Parametrised player-ship controller for the SpaceInvaders top. It replaces the inline fixed-step bar state machine with a configurable block that adds the following:
- bounded, saturating horizontal movement;
- hold-to-repeat;
- a single-projectile shot engine.
Outputs drive the nave renderer (pos_x) and a future shot renderer and collision logic (shot_x, shot_y, shot_active).

Parameters:
POS_W, 11, width of all coordinate ports
X_MIN, 134, leftmost ship position
X_MAX, 765, rightmost ship position
X_START, 445, position after reset/restart
STEP, 16, pixels moved per step
TICK_DIV, 524288, clk cycles per game tick (>=2)
REPEAT_TICKS, 4, ticks between repeated steps while held (>=1)
SHOT_Y_START, 470, shot y at launch
SHOT_Y_MIN, 55, shot y top limit
SHOT_STEP, 8, shot pixels per tick

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous active-low reset
btn_left  in  1  move left, active-low, asynchronous to clk
btn_right  in  1  move right, active-low
btn_fire  in  1  fire, active-low
btn_restart  in  1  game restart, active-low
hit  in  1  collision from external logic, active-high level
pos_x  out  POS_W  ship x position
shot_x  out  POS_W  shot x
shot_y  out  POS_W  shot y
shot_active  out  1  shot in flight
fire_pulse  out  1  one-cycle strobe on launch
moving  out  1  movement FSM in HOLD

Behaviour:
- Reset (async, reset=0):
  - Outputs: pos_x=X_START; shot_x=0; shot_y=0; shot_active=0; fire_pulse=0; moving=0.
  - Internal: both FSMs idle; tick counter 0; rep_cnt 0; fire_req 0.
  - Synchroniser flops preset to 1 (released).
- Input sync: each button passes through 2 flops. pressed_* = ~synced. All logic uses the synced values only, giving 2-cycle input latency.
- Tick: counter runs 0..TICK_DIV-1. tick=1 for the single cycle where the counter equals TICK_DIV-1, then it wraps to 0.
- Restart (synced btn_restart pressed):
  - Synchronously applies the reset values, except the synchronisers.
  - Held every cycle while the button is pressed; overrides all other events.
- Movement FSM (evaluated only on tick):
  - IDLE:
    - Exactly one of left/right pressed: take one step in that direction, latch the direction, rep_cnt=0, go to HOLD.
    - Both or neither pressed: no change.
  - HOLD:
    - Latched direction still pressed and the opposite not pressed:
      - rep_cnt==REPEAT_TICKS-1: step, rep_cnt=0.
      - Otherwise rep_cnt++.
    - Any other input: go to IDLE with no step that tick.
  - moving=1 in HOLD.
- Step arithmetic: computed in POS_W+1 bits, saturating.
  - Right: pos+STEP > X_MAX gives X_MAX.
  - Left: pos < X_MIN+STEP gives X_MIN.
  - pos_x never leaves [X_MIN, X_MAX].
- Fire request:
  - A synced press edge (1 to 0) sets fire_req.
  - fire_req is cleared on the next tick, whether or not the shot launches. Presses made while a shot is in flight are dropped.
- Shot FSM:
  - S_IDLE, on tick with fire_req:
    - shot_x = pos_x value before this tick's move; shot_y = SHOT_Y_START.
    - shot_active=1; fire_pulse=1 for exactly that cycle; go to S_FLY.
  - S_FLY, on tick:
    - shot_y < SHOT_Y_MIN+SHOT_STEP: go to S_IDLE, shot_active=0. shot_x/shot_y hold their last values.
    - Otherwise shot_y -= SHOT_STEP.
  - S_FLY, hit=1 on any cycle, tick or not: S_IDLE and shot_active=0 on the next edge. hit beats tick in the same cycle. hit is ignored in S_IDLE.
- Movement and shot FSMs update on the same tick independently.
- Parameter legality (simulation assertion): X_MIN+STEP <= X_MAX; X_MIN <= X_START <= X_MAX; SHOT_Y_MIN < SHOT_Y_START; all values < 2^POS_W.

Test Plan:
Bench setup for all cases: TICK_DIV=4, REPEAT_TICKS=2, other parameters at default.

1. Reset: reset low mid-run -> pos_x=445, shot_active=0, fire_pulse=0 immediately (async). Release, no buttons, 20 ticks -> pos_x stays 445.
2. Right hold: btn_right held -> pos_x goes 461 on the first tick, then +16 every 2 ticks, and saturates at 765 (from 749, then 765, never 781); moving=1. Release -> moving=0 on the next tick.
3. Left saturation: start 445, hold btn_left -> pos_x reaches 141, then 134, and stays 134.
4. Both buttons held -> pos_x unchanged. Right then left with no idle tick -> one step right, then IDLE, then stepping left.
5. Fire: press fire at pos 445 -> at the next tick shot_x=445, shot_y=470, fire_pulse is one cycle wide. shot_y falls 8 per tick until 62, then shot_active=0 at the tick after. A second press mid-flight produces no fire_pulse.
6. hit during flight, including on a tick cycle -> shot_active=0 next cycle. btn_restart pulse mid-flight -> pos_x=445, shot cleared, tick counter restarts from 0.
